// File: rtl/cv32e40p_debug_entry_sched.sv
// cv32e40p_debug_entry_sched: prioritises debug entry causes, drains the LSU,
// handshakes entry with the controller and tracks debug mode until dret.
module cv32e40p_debug_entry_sched #(
    parameter int unsigned FLUSH_MAX = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       insn_valid_i,
    input  logic       trigger_match_i,
    input  logic       ebrk_insn_i,
    input  logic       ebrk_force_debug_mode_i,
    input  logic       debug_req_i,
    input  logic       debug_single_step_i,
    input  logic       lsu_busy_i,
    input  logic       data_err_i,
    input  logic       entry_ack_i,
    input  logic       dret_i,
    output logic       entry_req_o,
    output logic [2:0] entry_cause_o,
    output logic       entry_if_o,
    output logic       cause_we_o,
    output logic       debug_mode_o,
    output logic       flush_timeout_o
);
    localparam int unsigned CW = $clog2(FLUSH_MAX + 1);
    typedef enum logic [1:0] {IDLE, FLUSH, REQ, DEBUG} state_e;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [2:0]    cause_q, win_cause;
    logic          if_q, we_q, dbg_q, halt_pending_q, step_armed_q, step_hit_q, win, cnt_max;
    assign entry_req_o   = state_q == REQ;
    assign entry_cause_o = cause_q;
    assign entry_if_o    = if_q;
    assign cause_we_o    = we_q & entry_req_o;
    assign debug_mode_o  = dbg_q;
    assign cnt_max       = cnt_q == CW'(FLUSH_MAX);
    always_comb begin
        win_cause = trigger_match_i                           ? 3'd2 :
                    (ebrk_insn_i & ebrk_force_debug_mode_i)   ? 3'd1 :
                    (halt_pending_q | debug_req_i)            ? 3'd3 :
                    step_hit_q                                ? 3'd4 : 3'd0;
        win             = insn_valid_i && win_cause != 3'd0;
        flush_timeout_o = 1'b0;
        state_d         = state_q;
        case (state_q)
            IDLE:  state_d = win ? FLUSH : IDLE;
            FLUSH: begin
                // a bus error aborts the drain; re-entry from debug mode falls back to DEBUG
                if (data_err_i) state_d = dbg_q ? DEBUG : IDLE;
                else if (!lsu_busy_i) state_d = REQ;
                else if (cnt_max) begin
                    flush_timeout_o = 1'b1;
                    state_d         = REQ;
                end
            end
            REQ:   state_d = entry_ack_i ? DEBUG : REQ;
            DEBUG: state_d = dret_i ? IDLE : (ebrk_insn_i & insn_valid_i) ? FLUSH : DEBUG;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            cause_q        <= 3'd0;
            if_q           <= 1'b0;
            we_q           <= 1'b0;
            dbg_q          <= 1'b0;
            halt_pending_q <= 1'b0;
            step_armed_q   <= 1'b0;
            step_hit_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (debug_req_i && !dbg_q) halt_pending_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (win) begin
                        cause_q <= win_cause;
                        if_q    <= win_cause == 3'd4;
                        we_q    <= 1'b1;
                        cnt_q   <= '0;
                    end else if (insn_valid_i && step_armed_q) begin
                        // the stepped instruction retires; the next one takes the step entry
                        step_armed_q <= 1'b0;
                        step_hit_q   <= 1'b1;
                    end
                end
                FLUSH: cnt_q <= cnt_max ? cnt_q : cnt_q + 1'b1;
                REQ: begin
                    if (entry_ack_i) begin
                        dbg_q          <= 1'b1;
                        halt_pending_q <= 1'b0;
                        step_armed_q   <= 1'b0;
                        step_hit_q     <= 1'b0;
                    end
                end
                DEBUG: begin
                    if (dret_i) begin
                        dbg_q        <= 1'b0;
                        step_armed_q <= debug_single_step_i;
                    end else if (ebrk_insn_i && insn_valid_i) begin
                        we_q  <= 1'b0;
                        if_q  <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cv32e40p_debug_entry_sched.sv
// tb_cv32e40p_debug_entry_sched: scenario tasks with randomized causes and
// LSU/ack timing, checked against expectations derived from the entry rules.
module tb_cv32e40p_debug_entry_sched;
    localparam int FMAX = 3;
    logic clk_i = 1'b0, rst_i = 1'b1;
    logic insn_valid_i, trigger_match_i, ebrk_insn_i, ebrk_force_debug_mode_i, debug_req_i;
    logic debug_single_step_i, lsu_busy_i, data_err_i, entry_ack_i, dret_i;
    logic entry_req_o, entry_if_o, cause_we_o, debug_mode_o, flush_timeout_o;
    logic [2:0] entry_cause_o;
    int errors = 0, checks = 0;

    cv32e40p_debug_entry_sched #(.FLUSH_MAX(FMAX)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .insn_valid_i(insn_valid_i),
        .trigger_match_i(trigger_match_i), .ebrk_insn_i(ebrk_insn_i),
        .ebrk_force_debug_mode_i(ebrk_force_debug_mode_i), .debug_req_i(debug_req_i),
        .debug_single_step_i(debug_single_step_i), .lsu_busy_i(lsu_busy_i),
        .data_err_i(data_err_i), .entry_ack_i(entry_ack_i), .dret_i(dret_i),
        .entry_req_o(entry_req_o), .entry_cause_o(entry_cause_o), .entry_if_o(entry_if_o),
        .cause_we_o(cause_we_o), .debug_mode_o(debug_mode_o), .flush_timeout_o(flush_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected cause from the priority rules (0 = no debug entry)
    function automatic int ref_cause(bit trig, bit ebrk, bit force_dm, bit halt, bit step);
        if (trig) return 2;
        if (ebrk && force_dm) return 1;
        if (halt) return 3;
        if (step) return 4;
        return 0;
    endfunction

    task tick;
        @(posedge clk_i);
        #1;
    endtask

    task clr;
        insn_valid_i = 0; trigger_match_i = 0; ebrk_insn_i = 0; ebrk_force_debug_mode_i = 0;
        debug_req_i = 0; debug_single_step_i = 0; lsu_busy_i = 0; data_err_i = 0;
        entry_ack_i = 0; dret_i = 0;
    endtask

    task wait_req(input int maxc, output int lat);
        lat = 0;
        while (!entry_req_o && lat < maxc) begin
            tick;
            lat++;
        end
    endtask

    task enter_debug_halt;
        int lat;
        clr; debug_req_i = 1; insn_valid_i = 1;
        tick; clr;
        wait_req(10, lat);
        entry_ack_i = 1;
        tick; clr;
    endtask

    task leave_debug(input bit step);
        dret_i = 1; debug_single_step_i = step;
        tick; clr;
    endtask

    task test_reset;
        clr; rst_i = 1;
        tick; tick;
        checks++;
        if ({entry_req_o, entry_cause_o, entry_if_o, cause_we_o, debug_mode_o, flush_timeout_o} !== 8'd0)
            begin errors++; $display("FAIL reset_outputs: got %b want 0", {entry_req_o, entry_cause_o, entry_if_o, cause_we_o, debug_mode_o, flush_timeout_o}); end
        rst_i = 0;
        tick; tick;
        checks++;
        if (entry_req_o !== 1'b0 || debug_mode_o !== 1'b0)
            begin errors++; $display("FAIL post_reset_idle: req=%b dbg=%b want 0 0", entry_req_o, debug_mode_o); end
    endtask

    task test_priority;
        int lat, k, d, exp;
        bit t, e, f, h, found, stable;
        for (int it = 0; it < 24; it++) begin
            t = 1'($urandom); e = 1'($urandom); f = 1'($urandom); h = 1'($urandom);
            k = $urandom_range(0, 2); d = $urandom_range(0, 2);
            exp = ref_cause(t, e, f, h, 1'b0);
            clr; insn_valid_i = 1; trigger_match_i = t; ebrk_insn_i = e;
            ebrk_force_debug_mode_i = f; debug_req_i = h;
            tick; clr;
            lat = 1; found = 0;
            while (lat < 12 && !found) begin
                if (entry_req_o) found = 1;
                else begin lsu_busy_i = (lat <= k); tick; lat++; end
            end
            lsu_busy_i = 0;
            checks++;
            if (exp == 0) begin
                if (found) begin errors++; $display("FAIL prio_no_entry it=%0d: req seen, want none", it); end
                continue;
            end
            if (!found || lat != k + 2 || entry_cause_o !== 3'(exp) || entry_if_o !== 1'b0 || cause_we_o !== 1'b1)
                begin errors++; $display("FAIL prio_entry it=%0d: found=%0d lat=%0d cause=%0d if=%b we=%b want 1 %0d %0d 0 1", it, found, lat, entry_cause_o, entry_if_o, cause_we_o, k + 2, exp); end
            stable = 1;
            for (int j = 0; j < d; j++) begin
                tick;
                if (!entry_req_o || entry_cause_o !== 3'(exp) || !cause_we_o) stable = 0;
            end
            checks++;
            if (!stable) begin errors++; $display("FAIL req_hold it=%0d: req/cause not stable before ack", it); end
            entry_ack_i = 1;
            tick; clr;
            checks++;
            if (debug_mode_o !== 1'b1 || entry_req_o !== 1'b0)
                begin errors++; $display("FAIL ack_to_debug it=%0d: dbg=%b req=%b want 1 0", it, debug_mode_o, entry_req_o); end
            leave_debug(1'b0);
            checks++;
            if (debug_mode_o !== 1'b0)
                begin errors++; $display("FAIL dret_exit it=%0d: dbg=%b want 0", it, debug_mode_o); end
        end
        clr; insn_valid_i = 1;
        tick; clr;
        found = 0;
        for (int j = 0; j < 5; j++) begin if (entry_req_o) found = 1; tick; end
        checks++;
        if (found) begin errors++; $display("FAIL halt_cleared: req=1 want 0"); end
    endtask

    task test_flush_timeout;
        int lat, pulses, lastp;
        clr; debug_req_i = 1; insn_valid_i = 1;
        tick; clr;
        pulses = 0; lastp = -1; lat = 0;
        while (!entry_req_o && lat < 20) begin
            lsu_busy_i = 1;
            #1;
            if (flush_timeout_o) begin pulses++; lastp = lat; end
            tick; lat++;
        end
        #1;
        if (flush_timeout_o) pulses++;
        checks++;
        if (pulses != 1 || lastp != lat - 1 || !entry_req_o || entry_cause_o !== 3'd3)
            begin errors++; $display("FAIL flush_timeout: pulses=%0d at=%0d req_at=%0d req=%b cause=%0d want 1 pulse then req cause 3", pulses, lastp, lat, entry_req_o, entry_cause_o); end
        checks++;
        if (lat < FMAX + 1)
            begin errors++; $display("FAIL flush_wait_len: got %0d cycles want >= %0d", lat, FMAX + 1); end
        clr; entry_ack_i = 1;
        tick; clr;
        leave_debug(1'b0);
    endtask

    task test_bus_error;
        int lat;
        bit seen;
        clr; debug_req_i = 1; insn_valid_i = 1;
        tick; clr; lsu_busy_i = 1;
        tick; data_err_i = 1; lsu_busy_i = 1;
        tick; clr;
        seen = 0;
        for (int j = 0; j < 6; j++) begin if (entry_req_o) seen = 1; tick; end
        checks++;
        if (seen) begin errors++; $display("FAIL bus_err_abort: req=1 want 0"); end
        insn_valid_i = 1;
        tick; clr;
        wait_req(10, lat);
        checks++;
        if (!entry_req_o || entry_cause_o !== 3'd3 || cause_we_o !== 1'b1)
            begin errors++; $display("FAIL bus_err_retry: req=%b cause=%0d we=%b want 1 3 1", entry_req_o, entry_cause_o, cause_we_o); end
        entry_ack_i = 1;
        tick; clr;
        leave_debug(1'b0);
    endtask

    task test_single_step;
        int lat;
        bit seen;
        enter_debug_halt;
        leave_debug(1'b1);
        checks++;
        if (debug_mode_o !== 1'b0) begin errors++; $display("FAIL step_dret: dbg=%b want 0", debug_mode_o); end
        insn_valid_i = 1;
        tick; clr;
        seen = 0;
        for (int j = 0; j < 5; j++) begin if (entry_req_o) seen = 1; tick; end
        checks++;
        if (seen) begin errors++; $display("FAIL step_first_retire: req=1 want 0"); end
        insn_valid_i = 1;
        tick; clr;
        wait_req(10, lat);
        checks++;
        if (!entry_req_o || entry_cause_o !== 3'd4 || entry_if_o !== 1'b1 || cause_we_o !== 1'b1)
            begin errors++; $display("FAIL step_entry: req=%b cause=%0d if=%b we=%b want 1 4 1 1", entry_req_o, entry_cause_o, entry_if_o, cause_we_o); end
        entry_ack_i = 1;
        tick; clr;
        leave_debug(1'b0);
    endtask

    task test_debug_ebreak;
        int lat;
        bit dbg_drop, seen;
        enter_debug_halt;
        debug_req_i = 1;
        tick; clr;
        ebrk_insn_i = 1; insn_valid_i = 1;
        tick; clr;
        dbg_drop = 0; lat = 0;
        while (!entry_req_o && lat < 10) begin
            if (!debug_mode_o) dbg_drop = 1;
            tick; lat++;
        end
        checks++;
        if (!entry_req_o || cause_we_o !== 1'b0 || entry_if_o !== 1'b0 || entry_cause_o !== 3'd3 || debug_mode_o !== 1'b1 || dbg_drop)
            begin errors++; $display("FAIL dbg_ebreak: req=%b we=%b if=%b cause=%0d dbg=%b drop=%b want 1 0 0 3 1 0", entry_req_o, cause_we_o, entry_if_o, entry_cause_o, debug_mode_o, dbg_drop); end
        entry_ack_i = 1;
        tick; clr;
        checks++;
        if (debug_mode_o !== 1'b1 || entry_req_o !== 1'b0)
            begin errors++; $display("FAIL dbg_reentry_ack: dbg=%b req=%b want 1 0", debug_mode_o, entry_req_o); end
        dret_i = 1; ebrk_insn_i = 1; insn_valid_i = 1;
        tick; clr;
        checks++;
        if (debug_mode_o !== 1'b0) begin errors++; $display("FAIL dret_wins: dbg=%b want 0", debug_mode_o); end
        seen = 0;
        for (int j = 0; j < 5; j++) begin if (entry_req_o) seen = 1; tick; end
        checks++;
        if (seen) begin errors++; $display("FAIL dret_wins_noreq: req=1 want 0"); end
    endtask

    task test_ack_ignored;
        bit bad;
        clr; bad = 0;
        entry_ack_i = 1;
        for (int j = 0; j < 4; j++) begin tick; if (debug_mode_o || entry_req_o) bad = 1; end
        clr;
        checks++;
        if (bad) begin errors++; $display("FAIL ack_outside_req: dbg/req asserted, want 0"); end
    endtask

    task test_async_reset;
        int lat;
        enter_debug_halt;
        ebrk_insn_i = 1; insn_valid_i = 1;
        tick; clr;
        wait_req(10, lat);
        checks++;
        if (!entry_req_o || !debug_mode_o)
            begin errors++; $display("FAIL pre_reset_req: req=%b dbg=%b want 1 1", entry_req_o, debug_mode_o); end
        #2 rst_i = 1;
        #1;
        checks++;
        if (entry_req_o !== 1'b0 || debug_mode_o !== 1'b0 || entry_cause_o !== 3'd0)
            begin errors++; $display("FAIL async_reset: req=%b dbg=%b cause=%0d want 0 0 0", entry_req_o, debug_mode_o, entry_cause_o); end
        tick;
        rst_i = 0;
        tick;
    endtask

    initial begin
        test_reset;
        test_priority;
        test_flush_timeout;
        test_bus_error;
        test_single_step;
        test_debug_ebreak;
        test_ack_ignored;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
